// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, fetch FSM states and
// constants common to the fetch and decode stages.
package cpu_pkg;

  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] BUBBLE_INSTR_DEF = 16'h0000;
  localparam logic [3:0]         HLT_OPCODE       = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } fetch_state_t;

endpackage

// File: rtl/cla_16bit.sv
// 16-bit adder built from four 4-bit carry-lookahead groups.
// Group carries ripple from one group to the next.
module cla_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);

  logic [4:0] w_gc;

  assign w_gc[0] = i_cin;
  assign o_cout  = w_gc[4];

  for (genvar k = 0; k < 4; k++) begin : g_grp
    logic [3:0] w_g, w_p, w_c;
    logic       w_ci;

    assign w_g  = i_a[4*k +: 4] & i_b[4*k +: 4];
    assign w_p  = i_a[4*k +: 4] ^ i_b[4*k +: 4];
    assign w_ci = w_gc[k];

    assign w_c[0] = w_ci;
    assign w_c[1] = w_g[0] | (w_p[0] & w_ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_ci);

    assign w_gc[k+1] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                     | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                     | (&w_p & w_ci);

    assign o_sum[4*k +: 4] = w_p ^ w_c;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding imem requests
// and fills the IF/ID register through a one-entry skid buffer.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC     = 16'h0000,
  parameter logic [INSTR_W-1:0] BUBBLE_INSTR = BUBBLE_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  input  logic               stall,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  input  logic               hlt,
  output logic [INSTR_W-1:0] pc_output,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [INSTR_W-1:0] if_id_pc_inc,
  output logic               if_id_valid,
  output logic               halted
);

  fetch_state_t       r_state;
  logic [INSTR_W-1:0] r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] r_pc_inc;
  logic               r_valid;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [INSTR_W-1:0] r_skid_pc_inc;
  logic               r_squash;
  logic               r_req;
  logic               r_halted;

  logic [INSTR_W-1:0] w_pc_inc;
  logic               w_unused_cout;
  logic               w_slot_free;
  logic               w_consume;

  // PC+2 wraps naturally; the carry out is irrelevant.
  cla_16bit u_pc_add (
    .i_a    (r_pc),
    .i_b    (16'h0002),
    .i_cin  (1'b0),
    .o_sum  (w_pc_inc),
    .o_cout (w_unused_cout)
  );

  assign w_slot_free = !r_valid || !stall;
  assign w_consume   = r_valid && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= BUBBLE_INSTR;
      r_pc_inc      <= '0;
      r_valid       <= 1'b0;
      r_skid_instr  <= '0;
      r_skid_pc_inc <= '0;
      r_squash      <= 1'b0;
      r_req         <= 1'b0;
      r_halted      <= 1'b0;
    end else if (r_state != S_HALT) begin
      if (hlt && r_valid) begin
        r_state  <= S_HALT;
        r_halted <= 1'b1;
        r_req    <= 1'b0;
      end else begin
        r_req <= 1'b0;
        if (w_consume) begin
          r_valid <= 1'b0;
          r_instr <= BUBBLE_INSTR;
        end
        if (redirect) begin
          r_pc    <= redirect_pc;
          r_valid <= 1'b0;
          r_instr <= BUBBLE_INSTR;
          // An in-flight request with no response yet must be dropped on arrival.
          if (r_state == S_WAIT && !imem_valid) begin
            r_squash <= 1'b1;
          end else begin
            r_squash <= 1'b0;
            r_state  <= S_REQ;
            r_req    <= 1'b1;
          end
        end else begin
          case (r_state)
            S_IDLE: begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end
            S_REQ: r_state <= S_WAIT;
            S_WAIT: begin
              if (imem_valid) begin
                if (r_squash) begin
                  r_squash <= 1'b0;
                  r_state  <= S_REQ;
                  r_req    <= 1'b1;
                end else if (w_slot_free) begin
                  r_valid  <= 1'b1;
                  r_instr  <= imem_rdata;
                  r_pc_inc <= w_pc_inc;
                  r_pc     <= w_pc_inc;
                  r_state  <= S_REQ;
                  r_req    <= 1'b1;
                end else begin
                  r_skid_instr  <= imem_rdata;
                  r_skid_pc_inc <= w_pc_inc;
                  r_pc          <= w_pc_inc;
                  r_state       <= S_HOLD;
                end
              end
            end
            S_HOLD: begin
              if (!stall) begin
                r_valid  <= 1'b1;
                r_instr  <= r_skid_instr;
                r_pc_inc <= r_skid_pc_inc;
                r_state  <= S_REQ;
                r_req    <= 1'b1;
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign imem_req     = r_req;
  assign imem_addr    = r_pc;
  assign pc_output    = r_pc;
  assign if_id_instr  = r_instr;
  assign if_id_pc_inc = r_pc_inc;
  assign if_id_valid  = r_valid;
  assign halted       = r_halted;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 16-bit pipelined CPU, directly upstream of the PC-control/decode stage. It owns the architectural PC register and drives `pc_output` into PC control. It issues one-outstanding requests to a variable-latency instruction memory and fills the IF/ID pipeline register (instruction + PC+2) with a one-entry skid buffer for decode stalls. It honours branch redirects and halts permanently when decode reports HLT.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000: PC value after reset.
- `BUBBLE_INSTR`, default 16'h0000: value driven on `if_id_instr` when `if_id_valid`=0.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `imem_req`  out  1: request strobe, one cycle per request.
- `imem_addr`  out  16: fetch address, always equal to the PC.
- `imem_rdata`  in  16: instruction word, qualified by `imem_valid`.
- `imem_valid`  in  1: response strobe, at the earliest the cycle after `imem_req`.
- `stall`  in  1: decode cannot accept; IF/ID must hold.
- `redirect`  in  1: branch taken in decode.
- `redirect_pc`  in  16: branch target (PC-control `pc_next`).
- `hlt`  in  1: HLT decoded from the valid IF/ID entry.
- `pc_output`  out  16: current PC.
- `if_id_instr`  out  16, `if_id_pc_inc`  out  16, `if_id_valid`  out  1: IF/ID register.
- `halted`  out  1: fetch permanently stopped.

## Operation
- FSM states:
  - IDLE: reset only; go to REQ next edge.
  - REQ: `imem_req`=1; go to WAIT.
  - WAIT: wait for `imem_valid`.
  - HOLD: response buffered while stalled.
  - HALT: terminal.
- `imem_req` is high only in REQ. `imem_addr` = `pc_output` = PC.
- IF/ID slot is free at an edge if `if_id_valid`=0 or `stall`=0. A valid entry with `stall`=0 is consumed at that edge. If nothing new is loaded, `if_id_valid`←0 and `if_id_instr`←BUBBLE_INSTR.
- WAIT, `imem_valid`=1, squash flag set: discard the response, clear the flag, go to REQ.
- WAIT, `imem_valid`=1, slot free:
  - IF/ID ← {`imem_rdata`, PC+2, valid=1}.
  - PC←PC+2.
  - Go to REQ.
- WAIT, `imem_valid`=1, slot not free: skid ← `imem_rdata`, PC←PC+2, go to HOLD.
- HOLD: on the first edge with `stall`=0, IF/ID ← skid (pc_inc = value captured with it), go to REQ.
- Redirect (`redirect`=1 at an edge; priority over all except `hlt` and reset):
  - PC←`redirect_pc`; IF/ID and skid invalidated.
  - From WAIT with no response this cycle: set squash, stay in WAIT.
  - Otherwise (a response arriving this same cycle is discarded without setting squash): go to REQ.
- `hlt`=1 with `if_id_valid`=1 → HALT:
  - `halted`=1, `imem_req`=0.
  - PC and IF/ID frozen; pending response ignored.
  - Exit only via reset. `hlt` has priority over `redirect`.
- PC+2 is modulo 2^16: 16'hFFFE→16'h0000. `redirect_pc` is used unmodified.

## Timing
- Reset values (asynchronous on `rst_n` low):
  - PC=`RESET_PC`, state IDLE, squash=0.
  - `imem_req`=0, `if_id_valid`=0, `if_id_instr`=BUBBLE_INSTR, `if_id_pc_inc`=0, `halted`=0.
- First request is in cycle 1 after reset release. With a 1-cycle memory, IF/ID is valid from cycle 3.
- Throughput is one instruction per 2 cycles with a 1-cycle memory, or per (latency+1) cycles in general.
- All state changes occur on the rising edge. Inputs are sampled at the edge.
- Reset asserted mid-WAIT abandons the request. The memory must drop it, and no response is accepted before the next REQ.

## Structure
- Shared `cpu_pkg` holds the fetch-state enum, `BUBBLE_INSTR` default, HLT opcode constant 4'hF, and instruction width 16.
- PC+2 uses the existing `cla_16bit` sub-module (B=16'h0002, Cin=0). No other sub-module.

## Test plan
- Reset release, 1-cycle memory, mem[0]=16'h1234 → `imem_req`=1 with addr 16'h0000 in cycle 1; IF/ID = {16'h1234, 16'h0002, 1} in cycle 3.
- `stall` held high while the response to addr 16'h0002 arrives → HOLD with `imem_req`=0. Drop `stall` → next edge IF/ID shows that instruction once, with no duplicate or loss; next request is to 16'h0004.
- 3-cycle memory, `redirect`=1 with `redirect_pc`=16'h0040 one cycle after the request → that response is dropped, `if_id_valid`=0, next `imem_addr`=16'h0040.
- `redirect` in the same cycle as `imem_valid` → response discarded; REQ to the target on the next cycle.
- `hlt`=1 with a valid entry → `halted`=1; `imem_req`=0 and `pc_output` unchanged for 20 cycles. Reset → refetch from `RESET_PC`.
- `RESET_PC`=16'hFFFE → `if_id_pc_inc`=16'h0000 and second fetch to 16'h0000. Assert `rst_n`=0 mid-WAIT → all outputs take reset values immediately.
